// File: rtl/hld_seq_ctrl_if.sv
// Config handshake and sequencer outputs for the MDLL hold-control frame sequencer.
// Master drives enable/config; slave (the sequencer) drives frame timing and status.
interface hld_seq_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_n;
  logic             cfg_mode;
  logic             div_m;
  logic             hld_win;
  logic             m_sel;
  logic [CNT_W-1:0] frame_cnt;
  logic             busy;
  logic             cfg_err;

  modport master (
    output en, cfg_valid, cfg_n, cfg_mode,
    input  cfg_ready, div_m, hld_win, m_sel, frame_cnt, busy, cfg_err
  );

  modport slave (
    input  en, cfg_valid, cfg_n, cfg_mode,
    output cfg_ready, div_m, hld_win, m_sel, frame_cnt, busy, cfg_err
  );
endinterface

// File: rtl/hld_seq_ctrl.sv
// Frame sequencer for the MDLL hold-control path: div_m pulse, hold window and applied mode, all registered.
// Config accepted whenever nothing is pending; ratio/mode changes only take effect at frame boundaries.
module hld_seq_ctrl #(
  parameter int CNT_W    = 6,
  parameter int DEF_N    = 8,
  parameter int HOLD_LEN = 1,
  parameter int SETTLE   = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hld_seq_ctrl_if.slave bus
);

  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] act_n_q, act_n_d;
  logic             act_mode_q, act_mode_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_n_q, pend_n_d;
  logic             pend_mode_q, pend_mode_d;
  logic             err_q, err_d;
  logic             div_m_q, div_m_d;
  logic             hld_win_q, hld_win_d;
  logic             m_sel_q, m_sel_d;

  logic [CNT_W-1:0] neff;
  logic [CNT_W-1:0] neff_d;
  logic             running;
  logic             run_d;
  logic             wrap;
  logic             xfer;
  logic             legal;

  assign neff    = act_mode_q ? CNT_W'(2) : act_n_q;
  assign running = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wrap    = running && (cnt_q == neff - CNT_W'(1));
  assign xfer    = bus.cfg_valid && !pend_vld_q;
  assign legal   = bus.cfg_mode || (bus.cfg_n >= CNT_W'(2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      act_n_q     <= CNT_W'(DEF_N);
      act_mode_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_n_q    <= '0;
      pend_mode_q <= 1'b0;
      err_q       <= 1'b0;
      div_m_q     <= 1'b0;
      hld_win_q   <= 1'b0;
      m_sel_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      act_n_q     <= act_n_d;
      act_mode_q  <= act_mode_d;
      pend_vld_q  <= pend_vld_d;
      pend_n_q    <= pend_n_d;
      pend_mode_q <= pend_mode_d;
      err_q       <= err_d;
      div_m_q     <= div_m_d;
      hld_win_q   <= hld_win_d;
      m_sel_q     <= m_sel_d;
    end
  end

  // Outside a running frame a request lands straight in active; on the wrap cycle it also
  // bypasses pending so the very next frame uses it.
  always_comb begin
    act_n_d     = act_n_q;
    act_mode_d  = act_mode_q;
    pend_vld_d  = pend_vld_q;
    pend_n_d    = pend_n_q;
    pend_mode_d = pend_mode_q;
    err_d       = err_q;
    if (xfer && !legal) begin
      err_d = 1'b1;
    end else if (xfer && (!running || wrap)) begin
      act_n_d    = bus.cfg_n;
      act_mode_d = bus.cfg_mode;
    end else if (xfer) begin
      pend_vld_d  = 1'b1;
      pend_n_d    = bus.cfg_n;
      pend_mode_d = bus.cfg_mode;
    end
    if (wrap && pend_vld_q) begin
      act_n_d    = pend_n_q;
      act_mode_d = pend_mode_q;
      pend_vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = '0;
        if (!bus.en) begin
          state_d = S_IDLE;
        end else if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        if (!bus.en) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        if (wrap) state_d = bus.en ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-cycle state so the registered values line up with frame_cnt.
  assign run_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
  assign neff_d = act_mode_d ? CNT_W'(2) : act_n_d;

  always_comb begin
    div_m_d   = run_d && (cnt_d == neff_d - CNT_W'(1));
    hld_win_d = run_d && (cnt_d >= neff_d - CNT_W'(HOLD_LEN));
    m_sel_d   = run_d && act_mode_d;
  end

  assign bus.cfg_ready = !pend_vld_q;
  assign bus.div_m     = div_m_q;
  assign bus.hld_win   = hld_win_q;
  assign bus.m_sel     = m_sel_q;
  assign bus.frame_cnt = cnt_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_hld_seq_ctrl.sv
// Bench for hld_seq_ctrl: constant vector table, directed corner sequences, random run vs frame model.
module tb_hld_seq_ctrl;
  localparam int CNT_W = 6;
  localparam int DEF_N = 8;
  localparam int HOLD  = 1;
  localparam int SETTLE = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  hld_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hld_seq_ctrl #(.CNT_W(CNT_W), .DEF_N(DEF_N), .HOLD_LEN(HOLD), .SETTLE(SETTLE)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 settling, 2 running, 3 draining.
  typedef struct { int n; int mode; } cfg_t;
  int   m_phase, m_pos, m_left, m_n, m_mode;
  bit   m_err;
  bit   synced = 0;
  cfg_t m_pend[$];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_pos = 0; m_left = 0; m_n = DEF_N; m_mode = 0; m_err = 0;
    m_pend.delete();
    synced = 1;
  endfunction

  function automatic void model_check();
    int len = m_mode ? 2 : m_n;
    bit live = (m_phase >= 2);
    logic [5:0] want, got;
    int want_cnt = live ? m_pos : 0;
    want = {live && (m_pos == len - 1), live && (m_pos >= len - HOLD), live && (m_mode != 0),
            m_phase != 0, m_pend.size() == 0, m_err};
    got  = {bus.div_m, bus.hld_win, bus.m_sel, bus.busy, bus.cfg_ready, bus.cfg_err};
    n_cmp++;
    if (got !== want || bus.frame_cnt !== CNT_W'(want_cnt)) begin
      n_bad++;
      $display("FAIL model t=%0t: got div/hld/msel/busy/rdy/err=%b cnt=%0d, want %b cnt=%0d",
               $time, got, bus.frame_cnt, want, want_cnt);
    end
  endfunction

  function automatic void model_step(bit en, bit v, int n, bit mode);
    int   len  = m_mode ? 2 : m_n;
    bit   live = (m_phase >= 2);
    bit   last = live && (m_pos == len - 1);
    cfg_t c;
    if (v && m_pend.size() == 0) begin
      if (!mode && n < 2) m_err = 1;
      else if (!live || last) begin m_n = n; m_mode = mode; end
      else m_pend.push_back('{n, mode});
    end
    if (last && m_pend.size() > 0) begin
      c = m_pend.pop_front();
      m_n = c.n; m_mode = c.mode;
    end
    case (m_phase)
      0: if (en) begin m_phase = 1; m_left = SETTLE; end
      1: if (!en) m_phase = 0;
         else begin
           m_left--;
           if (m_left == 0) m_phase = 2;
         end
      2: begin m_pos = last ? 0 : m_pos + 1; if (!en) m_phase = 3; end
      default: begin
        m_pos = last ? 0 : m_pos + 1;
        if (last) m_phase = en ? 2 : 0;
      end
    endcase
    if (m_phase < 2) m_pos = 0;
  endfunction

  // One clock: drive at negedge, check the current cycle, advance model at the edge.
  task automatic cycle(bit rst, bit en, bit v, int n, bit mode);
    rst_i = rst; bus.en = en; bus.cfg_valid = v; bus.cfg_n = CNT_W'(n % 64); bus.cfg_mode = mode;
    if (synced) model_check();
    @(posedge clk_i);
    if (rst) model_reset();
    else if (synced) model_step(en, v, n % 64, mode);
    @(negedge clk_i);
  endtask

  task automatic wait_cnt(string name, int k, bit en);
    for (int i = 0; i < 200; i++) begin
      if (bus.busy && bus.frame_cnt == CNT_W'(k)) break;
      cycle(0, en, 0, 0, 0);
    end
    chk(name, bus.frame_cnt, k);
  endtask

  task automatic wait_div(string name, bit en);
    for (int i = 0; i < 200; i++) begin
      if (bus.div_m) break;
      cycle(0, en, 0, 0, 0);
    end
    chk(name, bus.div_m, 1);
  endtask

  task automatic meas_frame(string name, int want);
    int len = 1;
    wait_div({name, "_div"}, 1);
    cycle(0, 1, 0, 0, 0);
    while (!bus.div_m && len < 200) begin
      cycle(0, 1, 0, 0, 0);
      len++;
    end
    chk(name, len, want);
  endtask

  typedef struct {
    bit rst; bit en; bit v; int n; bit mode;
    bit e_busy; int e_cnt; bit e_div; bit e_hld; bit e_rdy; bit e_err;
  } vec_t;
  vec_t tbl[$];

  function automatic void addv(bit rst, bit en, bit v, int n, bit mode,
                               bit e_busy, int e_cnt, bit e_div, bit e_hld, bit e_rdy, bit e_err);
    tbl.push_back('{rst, en, v, n, mode, e_busy, e_cnt, e_div, e_hld, e_rdy, e_err});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit en_lvl;
    // Expected outputs are those seen in the cycle after each row's edge.
    addv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < SETTLE; i++) addv(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)      addv(0, 1, 0, 0, 0, 1, i, i == 7, i == 7, 1, 0);
    addv(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    addv(0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1);
    addv(0, 1, 0, 0, 0, 1, 2, 0, 0, 1, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].n, tbl[i].mode);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_cnt", i), bus.frame_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_div", i), bus.div_m, tbl[i].e_div);
      chk($sformatf("tbl%0d_hld", i), bus.hld_win, tbl[i].e_hld);
      chk($sformatf("tbl%0d_rdy", i), bus.cfg_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_err", i), bus.cfg_err, tbl[i].e_err);
    end

    // Rejected config leaves the ratio at 8.
    meas_frame("t4_len8", 8);

    // Ratio change mid-frame waits for the wrap.
    wait_cnt("t2_at3", 3, 1);
    cycle(0, 1, 1, 5, 0);
    chk("t2_rdy_low", bus.cfg_ready, 0);
    wait_div("t2_div", 1);
    chk("t2_old_end", bus.frame_cnt, 7);
    chk("t2_rdy_wrap", bus.cfg_ready, 0);
    cycle(0, 1, 0, 0, 0);
    chk("t2_rdy_back", bus.cfg_ready, 1);
    meas_frame("t2_len5", 5);

    // Half-rate mode.
    wait_cnt("t3_at1", 1, 1);
    cycle(0, 1, 1, 0, 1);
    chk("t3_msel_old", bus.m_sel, 0);
    wait_div("t3_div", 1);
    cycle(0, 1, 0, 0, 0);
    chk("t3_msel_new", bus.m_sel, 1);
    chk("t3_div0", bus.div_m, 0);
    cycle(0, 1, 0, 0, 0);
    chk("t3_div1", bus.div_m, 1);
    chk("t3_hld1", bus.hld_win, 1);
    meas_frame("t3_len2", 2);
    cycle(0, 1, 1, 8, 0);
    meas_frame("t3_back8", 8);

    // Drain to idle.
    wait_cnt("t5_at2", 2, 1);
    cycle(0, 0, 0, 0, 0);
    chk("t5_busy_drain", bus.busy, 1);
    wait_div("t5_div", 0);
    chk("t5_div_cnt", bus.frame_cnt, 7);
    cycle(0, 0, 0, 0, 0);
    chk("t5_idle", bus.busy, 0);

    // Drain with enable re-raised: straight back to run.
    for (int i = 0; i < SETTLE + 1; i++) cycle(0, 1, 0, 0, 0);
    chk("t5b_run", bus.busy, 1);
    wait_cnt("t5b_at2", 2, 1);
    cycle(0, 0, 0, 0, 0);
    wait_cnt("t5b_at5", 5, 0);
    wait_div("t5b_div", 1);
    cycle(0, 1, 0, 0, 0);
    chk("t5b_cnt0", bus.frame_cnt, 0);
    cycle(0, 1, 0, 0, 0);
    chk("t5b_cnt1", bus.frame_cnt, 1);

    // Reset with a config pending.
    wait_cnt("t6_at1", 1, 1);
    cycle(0, 1, 1, 5, 0);
    wait_cnt("t6_at4", 4, 1);
    chk("t6_pending", bus.cfg_ready, 0);
    cycle(1, 1, 0, 0, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_cnt", bus.frame_cnt, 0);
    chk("t6_rdy", bus.cfg_ready, 1);
    chk("t6_outs", {bus.div_m, bus.hld_win, bus.m_sel, bus.cfg_err}, 0);
    meas_frame("t6_len8", 8);

    // Random traffic against the model.
    en_lvl = 1;
    for (int i = 0; i < 4000; i++) begin
      int n;
      if ($urandom_range(0, 19) == 0) en_lvl = ~en_lvl;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 63);
      cycle($urandom_range(0, 499) == 0, en_lvl, $urandom_range(0, 3) == 0, n,
            $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
